stickman_motion: RTL and testbench

- Vertical physics engine for the stickman: handles jump, double-jump, gravity, landing and ceiling/floor clamping.
- Updates once per frame tick and produces StickmanTop, which game_logic consumes for crash, fall and coin checks.
- Sits directly upstream of game_logic.
- Takes the game status back from game_logic so motion runs only while playing.

---
 rtl/stickman_motion.sv | 142 ++++++++++++++
 tb/tb_stickman_motion.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stickman_motion.sv
// Vertical motion engine for the stickman: jump, double jump, gravity, landing and
// screen clamping. The state advances once per frame tick while the game is playing.
module stickman_motion #(
    parameter int          STICK_H    = 50,
    parameter int          START_TOP  = 380,
    parameter int          JUMP_V     = 12,
    parameter int          GRAVITY    = 1,
    parameter int          MAX_FALL_V = 15,
    parameter int          MAX_JUMPS  = 2,
    parameter logic [7:0]  KEY_JUMP   = 8'h2c
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic [7:0]        keycode,
    input  logic [3:0]        status,
    input  logic [9:0]        GroundY,
    output logic [9:0]        StickmanTop,
    output logic signed [5:0] VelY,
    output logic              airborne,
    output logic [1:0]        jump_count
);

    localparam logic [3:0] ST_WAIT = 4'b1000;
    localparam logic [3:0] ST_PLAY = 4'b0100;

    localparam logic signed [10:0] H_S      = 11'(STICK_H);
    localparam logic signed [10:0] JV_S     = 11'(JUMP_V);
    localparam logic signed [10:0] G_S      = 11'(GRAVITY);
    localparam logic signed [10:0] MF_S     = 11'(MAX_FALL_V);
    localparam logic signed [10:0] BOTTOM_S = 11'sd479;
    localparam logic signed [10:0] GAP_S    = 11'sd480;
    localparam logic [9:0]         START_POS = 10'(START_TOP);
    localparam logic [9:0]         FLOOR_TOP = 10'(479 - STICK_H);

    logic                 frame_clk_d;
    logic [7:0]           key_prev;
    logic                 jump_req;
    logic                 tick;
    logic                 press;
    logic                 do_jump;

    logic signed [10:0]   top_s;
    logic signed [10:0]   feet_s;
    logic signed [10:0]   ground_s;
    logic signed [10:0]   vel_s;
    logic signed [10:0]   v;
    logic signed [10:0]   new_top;
    logic signed [10:0]   new_feet;

    logic [9:0]           nxt_top;
    logic signed [5:0]    nxt_vel;
    logic                 nxt_air;
    logic [1:0]           nxt_jc;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        tick     = frame_clk & ~frame_clk_d;
        press    = (keycode == KEY_JUMP) && (key_prev != KEY_JUMP);
        top_s    = {1'b0, StickmanTop};
        ground_s = {1'b0, GroundY};
        vel_s    = {{5{VelY[5]}}, VelY};
        feet_s   = top_s + H_S;
        // A press arriving on the tick cycle itself is honoured by that tick.
        do_jump  = (jump_req | press) && (jump_count < 2'(MAX_JUMPS));
        nxt_air  = airborne;
        nxt_jc   = jump_count;

        if (do_jump) begin
            v       = -JV_S;
            nxt_jc  = jump_count + 2'd1;
            nxt_air = 1'b1;
        end else if (airborne) begin
            v = (vel_s + G_S > MF_S) ? MF_S : vel_s + G_S;
        end else if (ground_s > feet_s) begin
            // Walked off a ledge: falling, with one air jump left.
            v       = G_S;
            nxt_air = 1'b1;
            nxt_jc  = 2'd1;
        end else begin
            v = 11'sd0;
        end

        new_top  = top_s + v;
        new_feet = new_top + H_S;
        nxt_top  = new_top[9:0];
        nxt_vel  = v[5:0];

        // Landing only from above a real surface; GroundY at or past 480 is a gap.
        if (v > 11'sd0 && ground_s < GAP_S && feet_s <= ground_s && new_feet >= ground_s) begin
            nxt_top = 10'(ground_s - H_S);
            nxt_vel = 6'sd0;
            nxt_air = 1'b0;
            nxt_jc  = 2'd0;
        end else if (new_top < 11'sd0) begin
            nxt_top = 10'd0;
            nxt_vel = 6'sd0;
        end else if (new_feet > BOTTOM_S) begin
            nxt_top = FLOOR_TOP;
        end
    end

    // NOTE: reset is synchronous and all state uses non-blocking assignments.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_clk_d <= 1'b0;
            key_prev    <= 8'd0;
            jump_req    <= 1'b0;
            StickmanTop <= START_POS;
            VelY        <= 6'sd0;
            airborne    <= 1'b0;
            jump_count  <= 2'd0;
        end else begin
            frame_clk_d <= frame_clk;
            key_prev    <= keycode;

            if (status != ST_PLAY || tick)
                jump_req <= 1'b0;
            else if (press)
                jump_req <= 1'b1;

            if (tick) begin
                case (status)
                    ST_WAIT: begin
                        StickmanTop <= START_POS;
                        VelY        <= 6'sd0;
                        airborne    <= 1'b0;
                        jump_count  <= 2'd0;
                    end
                    ST_PLAY: begin
                        StickmanTop <= nxt_top;
                        VelY        <= nxt_vel;
                        airborne    <= nxt_air;
                        jump_count  <= nxt_jc;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stickman_motion.sv
// Self-checking bench for stickman_motion: directed scenarios with literal expectations
// plus randomized frames, all compared each cycle against an integer reference model.
module tb_stickman_motion;

    localparam logic [7:0] KEY  = 8'h2c;
    localparam logic [3:0] WAIT = 4'b1000;
    localparam logic [3:0] PLAY = 4'b0100;
    localparam logic [3:0] WIN  = 4'b0010;
    localparam logic [3:0] LOSE = 4'b0001;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              frame_clk;
    logic [7:0]        keycode;
    logic [3:0]        status;
    logic [9:0]        GroundY;
    logic [9:0]        StickmanTop;
    logic signed [5:0] VelY;
    logic              airborne;
    logic [1:0]        jump_count;

    stickman_motion dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .keycode     (keycode),
        .status      (status),
        .GroundY     (GroundY),
        .StickmanTop (StickmanTop),
        .VelY        (VelY),
        .airborne    (airborne),
        .jump_count  (jump_count)
    );

    always #10 Clk = ~Clk;

    int n_cmp = 0;
    int n_err = 0;
    bit model_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, $signed(act), act, $signed(exp), exp, $time);
        end
    endtask

    // Reference model: plain integer physics evaluated from the game rules.
    int m_top, m_vel, m_jc;
    bit m_air, m_req, m_fclk_prev;
    logic [7:0] m_key_prev;

    task automatic model_physics(input bit want_jump);
        int feet, v, nt, g;
        feet = m_top + 50;
        g    = int'(GroundY);
        if (want_jump && m_jc < 2) begin
            v = -12; m_jc = m_jc + 1; m_air = 1;
        end else if (m_air) begin
            v = (m_vel + 1 > 15) ? 15 : m_vel + 1;
        end else if (g > feet) begin
            v = 1; m_air = 1; m_jc = 1;
        end else begin
            v = 0;
        end
        nt = m_top + v;
        if (v > 0 && g < 480 && feet <= g && nt + 50 >= g) begin
            m_top = g - 50; m_vel = 0; m_air = 0; m_jc = 0;
        end else if (nt < 0) begin
            m_top = 0; m_vel = 0;
        end else if (nt + 50 > 479) begin
            m_top = 429; m_vel = v;
        end else begin
            m_top = nt; m_vel = v;
        end
    endtask

    always @(posedge Clk) begin
        bit tk, pr;
        if (Reset) begin
            m_top = 380; m_vel = 0; m_air = 0; m_jc = 0;
            m_req = 0; m_key_prev = 8'd0; m_fclk_prev = 0;
        end else begin
            tk = frame_clk && !m_fclk_prev;
            pr = (keycode == KEY) && (m_key_prev != KEY);
            if (tk) begin
                if (status == WAIT) begin
                    m_top = 380; m_vel = 0; m_air = 0; m_jc = 0;
                end else if (status == PLAY) begin
                    model_physics(m_req || pr);
                end
            end
            if (status != PLAY || tk) m_req = 0;
            else if (pr) m_req = 1;
            m_key_prev  = keycode;
            m_fclk_prev = frame_clk;
        end
    end

    // Cycle-by-cycle comparison of {top, vel, airborne, jump_count}.
    always @(posedge Clk) begin
        #1;
        if (model_on)
            check("state{top,vel,air,jc}",
                  {13'd0, StickmanTop, VelY, airborne, jump_count},
                  {13'd0, 10'(m_top), 6'(m_vel), m_air, 2'(m_jc)});
    end

    task automatic frame();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press_key();
        @(negedge Clk);
        keycode = KEY;
        @(negedge Clk);
        keycode = 8'd0;
    endtask

    task automatic wait_landing(input string name);
        int n;
        n = 0;
        while (airborne && n < 60) begin
            frame();
            n++;
        end
        check(name, 32'(airborne), 32'd0);
    endtask

    task automatic check_pos(input string name, input int top, input int vel);
        check({name, "_top"}, 32'(StickmanTop), 32'(top));
        check({name, "_vel"}, 32'($signed(VelY)), 32'(vel));
    endtask

    int grounds[8] = '{100, 250, 380, 400, 430, 450, 480, 600};

    initial begin
        int hi, lo, kr, r;
        Reset = 1'b1; frame_clk = 1'b0; keycode = 8'd0; status = WAIT; GroundY = 10'd430;
        @(negedge Clk);
        @(negedge Clk);
        model_on = 1'b1;
        check_pos("reset", 380, 0);
        check("reset_air", 32'(airborne), 32'd0);
        check("reset_jc", 32'(jump_count), 32'd0);
        Reset = 1'b0;

        // Waiting: key presses and ticks leave the stickman parked.
        frame(); press_key(); frames(2); press_key(); frame();
        check_pos("wait", 380, 0);
        check("wait_air", 32'(airborne), 32'd0);

        // Single jump: launch, apex on tick 13, landing on tick 25.
        status = PLAY;
        press_key();
        frame();
        check_pos("jump_t1", 368, -12);
        frames(12);
        check_pos("apex_t13", 302, 0);
        frames(12);
        check_pos("land_t25", 380, 0);
        check("land_air", 32'(airborne), 32'd0);
        check("land_jc", 32'(jump_count), 32'd0);

        // Double jump, then a third press that must be ignored.
        press_key(); frames(5);
        check_pos("dj_pre", 330, -8);
        press_key(); frame();
        check_pos("dj_launch", 318, -12);
        check("dj_jc", 32'(jump_count), 32'd2);
        press_key(); frame();
        check("dj_third_vel", 32'($signed(VelY)), 32'(-11));
        check("dj_third_jc", 32'(jump_count), 32'd2);
        wait_landing("dj_landed");
        check_pos("dj_rest", 380, 0);

        // Key held across WAIT->PLAY must not jump; a re-press must.
        status = WAIT; frame();
        keycode = KEY; frame();
        status = PLAY; frames(3);
        check_pos("held", 380, 0);
        @(negedge Clk); keycode = 8'd0;
        @(negedge Clk); keycode = KEY;
        frame();
        check_pos("repress", 368, -12);
        keycode = 8'd0;
        wait_landing("repress_landed");

        // Ground drops away: fall with growing speed, capped, clamped at the floor.
        GroundY = 10'd480;
        frame();
        check_pos("gap_t1", 381, 1);
        check("gap_jc", 32'(jump_count), 32'd1);
        frames(19);
        check_pos("gap_floor", 429, 15);
        check("gap_air", 32'(airborne), 32'd1);

        // Back to waiting, then freeze on LOSE mid-jump, then reset mid-jump.
        status = WAIT; frame();
        GroundY = 10'd430; status = PLAY;
        press_key(); frames(3);
        check_pos("pre_freeze", 347, -10);
        status = LOSE; frames(10);
        check_pos("frozen", 347, -10);
        check("frozen_jc", 32'(jump_count), 32'd1);
        status = WIN; frames(2);
        check_pos("frozen_win", 347, -10);
        status = PLAY; frames(2);
        @(negedge Clk); Reset = 1'b1;
        @(negedge Clk);
        check_pos("midjump_reset", 380, 0);
        check("midjump_reset_air", 32'(airborne), 32'd0);
        Reset = 1'b0;

        // Randomized frames checked against the model every cycle.
        for (int f = 0; f < 500; f++) begin
            r = $urandom_range(0, 99);
            @(negedge Clk);
            status = (r < 85) ? PLAY : (r < 91) ? WAIT : (r < 94) ? WIN : (r < 97) ? LOSE : 4'b0110;
            if ($urandom_range(0, 9) == 0) GroundY = 10'(grounds[$urandom_range(0, 7)]);
            frame_clk = 1'b1;
            hi = $urandom_range(1, 4);
            lo = $urandom_range(1, 8);
            for (int c = 0; c < hi + lo; c++) begin
                if (c == hi) frame_clk = 1'b0;
                kr = $urandom_range(0, 9);
                if (kr < 2) keycode = KEY;
                else if (kr < 4) keycode = 8'd0;
                else if (kr == 4) keycode = 8'($urandom);
                Reset = ($urandom_range(0, 399) == 0);
                @(negedge Clk);
            end
            Reset = 1'b0;
        end

        @(negedge Clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
